// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper ramp driver: step-mode encodings,
// the 8-entry coil phase table, the profile state type and small index helpers.
package stepper_pkg;

    localparam logic [1:0] MODE_WAVE = 2'b00;
    localparam logic [1:0] MODE_FULL = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;

    // Coil patterns (A,B,C,D) by phase index; element [0] is 1000.
    localparam logic [7:0][3:0] PHASE_PATTERN = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEL  = 2'd1,
        ST_CRUISE = 2'd2,
        ST_DECEL  = 2'd3
    } state_e;

    // Half mode walks every entry; wave and full skip alternate entries.
    function automatic logic [2:0] index_stride(input logic [1:0] mode);
        logic [2:0] stride;
        stride = (mode == MODE_HALF) ? 3'd1 : 3'd2;
        return stride;
    endfunction

    // Wave uses even entries, full (and the unused 11 code) uses odd ones.
    function automatic logic [2:0] align_index(input logic [2:0] idx, input logic [1:0] mode);
        logic [2:0] aligned;
        logic       need_odd;
        aligned  = idx;
        need_odd = (mode != MODE_WAVE);
        if ((mode != MODE_HALF) && (idx[0] != need_odd)) begin
            aligned = idx + 3'd1;
        end
        return aligned;
    endfunction

endpackage

// File: rtl/stepper_ramp_driver_if.sv
// Command / status bundle between the PIO command registers and the stepper driver.
//   cmd_start, cmd_stop : single-cycle command pulses
//   cmd_dir, cmd_mode   : direction (1 = forward) and step mode
//   cmd_steps           : step count of the move
//   cmd_period_start/min, cmd_accel : trapezoidal profile settings (clk cycles)
//   coil_out, busy, done, position, steps_left : driver status and coil drive
interface stepper_ramp_driver_if #(
    parameter int PER_W  = 24,
    parameter int STEP_W = 16,
    parameter int POS_W  = 32
);
    logic                     cmd_start;
    logic                     cmd_stop;
    logic                     cmd_dir;
    logic [1:0]               cmd_mode;
    logic [STEP_W-1:0]        cmd_steps;
    logic [PER_W-1:0]         cmd_period_start;
    logic [PER_W-1:0]         cmd_period_min;
    logic [PER_W-1:0]         cmd_accel;
    logic [3:0]               coil_out;
    logic                     busy;
    logic                     done;
    logic signed [POS_W-1:0]  position;
    logic [STEP_W-1:0]        steps_left;

    modport master (
        output cmd_start, cmd_stop, cmd_dir, cmd_mode, cmd_steps,
               cmd_period_start, cmd_period_min, cmd_accel,
        input  coil_out, busy, done, position, steps_left
    );

    modport slave (
        input  cmd_start, cmd_stop, cmd_dir, cmd_mode, cmd_steps,
               cmd_period_start, cmd_period_min, cmd_accel,
        output coil_out, busy, done, position, steps_left
    );
endinterface

// File: rtl/stepper_ramp_driver_step_timer.sv
// Step interval timer: counts clock cycles and fires step_event on the cycle
// where the count reaches period-1, then restarts from zero.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : restart the count (move start)
//   enable     : count while a move is active
//   period     : current step period in cycles (never 0)
//   step_event : one-cycle step strobe
module step_timer #(
    parameter int PER_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [PER_W-1:0] period,
    output logic             step_event
);
    localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

    logic [PER_W-1:0] timer_q, timer_d;

    assign step_event = enable && (timer_q == (period - PER_ONE));

    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (enable) begin
            timer_d = step_event ? '0 : timer_q + PER_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
endmodule

// File: rtl/stepper_ramp_driver.sv
// Step/direction generator with trapezoidal speed profile for 4-wire stepper coils.
//   clk_clk, reset_reset : clock, asynchronous active-high reset
//   bus (slave)          : commands in, coil pattern / busy / done / position / steps_left out
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no move; accepts cmd_start
// ST_ACCEL  | period shrinks by accel per step down to period_min
// ST_CRUISE | stepping at period_min
// ST_DECEL  | period grows by accel per step back toward period_start
module stepper_ramp_driver
    import stepper_pkg::*;
#(
    parameter int PER_W   = 24,
    parameter int STEP_W  = 16,
    parameter int POS_W   = 32,
    parameter bit HOLD_EN = 1'b1
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    stepper_ramp_driver_if.slave bus
);
    localparam logic [PER_W-1:0]  PER_ONE  = PER_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);

    state_e            state_q, state_d;
    logic              dir_q, dir_d;
    logic [1:0]        mode_q, mode_d;
    logic [PER_W-1:0]  per_start_q, per_start_d;
    logic [PER_W-1:0]  per_min_q, per_min_d;
    logic [PER_W-1:0]  accel_q, accel_d;
    logic [PER_W-1:0]  cur_period_q, cur_period_d;
    logic [STEP_W-1:0] ramp_q, ramp_d;
    logic [STEP_W-1:0] left_q, left_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [2:0]        idx_q, idx_d;
    logic [3:0]        coil_q, coil_d;
    logic              done_q, done_d;

    logic              busy_w;
    logic              start_accept;
    logic              step_event;
    logic [PER_W-1:0]  ps_eff, pm_clip, pm_eff;
    logic [PER_W-1:0]  per_up, per_down;
    logic [STEP_W-1:0] left_dec;
    logic [STEP_W-1:0] stop_cap;
    logic [2:0]        idx_next;

    assign busy_w       = (state_q != ST_IDLE);
    assign start_accept = (state_q == ST_IDLE) && bus.cmd_start;

    // A zero period would never fire the timer, so both periods are floored at 1
    // and the cruise period may not be slower than the start period.
    assign ps_eff  = (bus.cmd_period_start == '0) ? PER_ONE : bus.cmd_period_start;
    assign pm_clip = (bus.cmd_period_min > ps_eff) ? ps_eff : bus.cmd_period_min;
    assign pm_eff  = (pm_clip == '0) ? PER_ONE : pm_clip;

    // cur_period always lies within [per_min, per_start], so the differences
    // below cannot underflow and the saturating compares avoid overflow.
    assign per_up   = (accel_q >= (per_start_q - cur_period_q)) ? per_start_q
                                                               : cur_period_q + accel_q;
    assign per_down = (accel_q >= (cur_period_q - per_min_q)) ? per_min_q
                                                             : cur_period_q - accel_q;

    assign left_dec = left_q - STEP_ONE;
    assign idx_next = dir_q ? (idx_q + index_stride(mode_q)) : (idx_q - index_stride(mode_q));

    step_timer #(.PER_W(PER_W)) u_step_timer (
        .clk        (clk_clk),
        .rst        (reset_reset),
        .clear      (start_accept),
        .enable     (busy_w),
        .period     (cur_period_q),
        .step_event (step_event)
    );

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        mode_d       = mode_q;
        per_start_d  = per_start_q;
        per_min_d    = per_min_q;
        accel_d      = accel_q;
        cur_period_d = cur_period_q;
        ramp_d       = ramp_q;
        left_d       = left_q;
        pos_d        = pos_q;
        idx_d        = idx_q;
        coil_d       = coil_q;
        done_d       = 1'b0;
        stop_cap     = '0;

        if (state_q == ST_IDLE) begin
            // cmd_stop is ignored here, so a coincident start simply wins.
            if (bus.cmd_start) begin
                dir_d        = bus.cmd_dir;
                mode_d       = bus.cmd_mode;
                per_start_d  = ps_eff;
                per_min_d    = pm_eff;
                accel_d      = bus.cmd_accel;
                cur_period_d = ps_eff;
                ramp_d       = '0;
                left_d       = bus.cmd_steps;
                idx_d        = align_index(idx_q, bus.cmd_mode);
                if (bus.cmd_steps == '0) begin
                    done_d = 1'b1;
                end else if ((bus.cmd_accel == '0) || (ps_eff == pm_eff)) begin
                    state_d = ST_CRUISE;
                end else begin
                    state_d = ST_ACCEL;
                end
            end
        end else begin
            if (step_event) begin
                idx_d  = idx_next;
                coil_d = PHASE_PATTERN[idx_next];
                pos_d  = dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
                left_d = left_dec;
                if (left_dec == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (!HOLD_EN) begin
                        coil_d = 4'b0000;
                    end
                end else if ((state_q != ST_DECEL) && (left_dec <= ramp_q)) begin
                    // Remaining distance only covers the ramp back down; the
                    // entry step already slows so the profile is symmetric.
                    state_d      = ST_DECEL;
                    cur_period_d = per_up;
                end else if (state_q == ST_ACCEL) begin
                    cur_period_d = per_down;
                    ramp_d       = ramp_q + STEP_ONE;
                    if (per_down == per_min_q) begin
                        state_d = ST_CRUISE;
                    end
                end else if (state_q == ST_DECEL) begin
                    cur_period_d = per_up;
                end
            end

            // A ramped stop keeps enough steps to retrace the ramp; with no ramp
            // the step already in progress is allowed to finish.
            if (bus.cmd_stop && (left_d != '0)) begin
                stop_cap = (ramp_d == '0) ? STEP_ONE : ramp_d;
                if (left_d > stop_cap) begin
                    left_d = stop_cap;
                end
                state_d = ST_DECEL;
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            mode_q       <= 2'b00;
            per_start_q  <= '0;
            per_min_q    <= '0;
            accel_q      <= '0;
            cur_period_q <= '0;
            ramp_q       <= '0;
            left_q       <= '0;
            pos_q        <= '0;
            idx_q        <= 3'd0;
            coil_q       <= 4'b0000;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            mode_q       <= mode_d;
            per_start_q  <= per_start_d;
            per_min_q    <= per_min_d;
            accel_q      <= accel_d;
            cur_period_q <= cur_period_d;
            ramp_q       <= ramp_d;
            left_q       <= left_d;
            pos_q        <= pos_d;
            idx_q        <= idx_d;
            coil_q       <= coil_d;
            done_q       <= done_d;
        end
    end

    assign bus.coil_out   = coil_q;
    assign bus.busy       = busy_w;
    assign bus.done       = done_q;
    assign bus.position   = pos_q;
    assign bus.steps_left = left_q;
endmodule

// File: tb/tb_stepper_ramp_driver.sv
module tb_stepper_ramp_driver;
    import stepper_pkg::*;

    localparam int PER_W  = 24;
    localparam int STEP_W = 16;
    localparam int POS_W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stepper_ramp_driver_if #(.PER_W(PER_W), .STEP_W(STEP_W), .POS_W(POS_W)) bus ();

    stepper_ramp_driver #(
        .PER_W(PER_W), .STEP_W(STEP_W), .POS_W(POS_W), .HOLD_EN(1'b1)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (bus)
    );

    typedef struct {
        logic       dir;
        logic [1:0] mode;
        int         steps;
        int         ps;
        int         pm;
        int         accel;
        int         stop_after;
        int         poke_cyc;
        bit         stop_with_start;
        int         exp_delta;
        logic [3:0] exp_coil;
        int         exp_cycles;
        int         tag;
    } move_t;

    typedef struct {
        int         interval;
        logic [3:0] coil;
        int         pos;
        int         left;
        bit         done;
    } step_t;

    logic [3:0] pat [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    step_t sb[$];
    int    obs_int[$];
    int    ref_int[$];
    int    total = 0;
    int    bad   = 0;
    int    m_idx = 0;
    int    m_pos = 0;
    move_t tbl [8];
    move_t extra;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, $signed(act), $signed(exp), $time);
        end
    endtask

    task automatic check_intervals(input string name);
        check({name, "_count"}, 32'(obs_int.size()), 32'(ref_int.size()));
        for (int i = 0; i < ref_int.size() && i < obs_int.size(); i++) begin
            check(name, 32'(obs_int[i]), 32'(ref_int[i]));
        end
    endtask

    // Reference model of the profile: pushes one record per expected step.
    task automatic model_move(input move_t m);
        int    ps_e, pm_e, cur, ramp, left, n, st, stride, cap;
        step_t r;
        ps_e = (m.ps == 0) ? 1 : m.ps;
        pm_e = (m.pm > ps_e) ? ps_e : m.pm;
        if (pm_e == 0) pm_e = 1;
        stride = (m.mode == 2'b10) ? 1 : 2;
        if (m.mode != 2'b10) begin
            if ((m_idx % 2) != ((m.mode == 2'b00) ? 0 : 1)) m_idx = (m_idx + 1) % 8;
        end
        if (m.steps == 0) return;
        cur = ps_e; ramp = 0; left = m.steps; n = 0;
        st = ((m.accel == 0) || (ps_e == pm_e)) ? 1 : 0;   // 0 accel, 1 cruise, 2 decel
        while (left > 0) begin
            r.interval = cur;
            m_idx = m.dir ? (m_idx + stride) % 8 : (m_idx + 8 - stride) % 8;
            m_pos = m.dir ? m_pos + 1 : m_pos - 1;
            left--; n++;
            r.coil = pat[m_idx]; r.pos = m_pos; r.left = left; r.done = (left == 0);
            if (left > 0) begin
                if (st != 2 && left <= ramp) begin
                    st = 2;
                    cur = (cur + m.accel > ps_e) ? ps_e : cur + m.accel;
                end else if (st == 0) begin
                    cur = (cur - m.accel < pm_e) ? pm_e : cur - m.accel;
                    ramp++;
                    if (cur == pm_e) st = 1;
                end else if (st == 2) begin
                    cur = (cur + m.accel > ps_e) ? ps_e : cur + m.accel;
                end
                if (n == m.stop_after) begin
                    cap = (ramp > 0) ? ramp : 1;
                    if (left > cap) left = cap;
                    st = 2;
                end
            end
            sb.push_back(r);
        end
    endtask

    task automatic run_move(input move_t m);
        int          cyc, last, limit, pos_before;
        bit          stop_pend, poke_pend;
        logic [31:0] prev_pos;
        step_t       e;
        pos_before = m_pos;
        model_move(m);
        @(negedge clk);
        bus.cmd_dir          = m.dir;
        bus.cmd_mode         = m.mode;
        bus.cmd_steps        = STEP_W'(m.steps);
        bus.cmd_period_start = PER_W'(m.ps);
        bus.cmd_period_min   = PER_W'(m.pm);
        bus.cmd_accel        = PER_W'(m.accel);
        bus.cmd_start        = 1'b1;
        bus.cmd_stop         = m.stop_with_start;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        bus.cmd_stop  = 1'b0;
        obs_int.delete();
        if (m.steps == 0) begin
            check("zero_done", 32'(bus.done), 32'd1);
            check("zero_busy", 32'(bus.busy), 32'd0);
            check("zero_left", 32'(bus.steps_left), 32'd0);
            check("zero_pos", bus.position, 32'(pos_before));
            @(negedge clk);
            check("zero_done_once", 32'(bus.done), 32'd0);
            return;
        end
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("left_loaded", 32'(bus.steps_left), 32'(m.steps));
        cyc = 0; last = 0; stop_pend = 0; poke_pend = 0;
        prev_pos = bus.position;
        limit = m.exp_cycles + 50;
        while (sb.size() > 0 && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (stop_pend) begin bus.cmd_stop = 1'b0; stop_pend = 0; end
            if (poke_pend) begin bus.cmd_start = 1'b0; poke_pend = 0; end
            if (bus.position !== prev_pos) begin
                e = sb.pop_front();
                check("interval", 32'(cyc - last), 32'(e.interval));
                check("coil", 32'(bus.coil_out), 32'(e.coil));
                check("position", bus.position, 32'(e.pos));
                check("steps_left", 32'(bus.steps_left), 32'(e.left));
                check("done_flag", 32'(bus.done), 32'(e.done));
                obs_int.push_back(cyc - last);
                last = cyc;
                prev_pos = bus.position;
                if (obs_int.size() == m.stop_after) begin bus.cmd_stop = 1'b1; stop_pend = 1; end
                if (e.done) check("done_cycle", 32'(cyc), 32'(m.exp_cycles));
            end else if (bus.done) begin
                check("spurious_done", 32'(bus.done), 32'd0);
            end
            if (cyc == m.poke_cyc) begin
                bus.cmd_start = 1'b1; bus.cmd_steps = 16'd77;
                bus.cmd_period_start = 24'd3; bus.cmd_dir = ~m.dir; poke_pend = 1;
            end
        end
        bus.cmd_start = 1'b0;
        bus.cmd_stop  = 1'b0;
        if (sb.size() > 0) begin
            check("step_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
        check("busy_end", 32'(bus.busy), 32'd0);
        check("done_end", 32'(bus.done), 32'd0);
        check("final_pos", bus.position, 32'(pos_before + m.exp_delta));
        check("final_coil", 32'(bus.coil_out), 32'(m.exp_coil));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.cmd_start = 0; bus.cmd_stop = 0; bus.cmd_dir = 0; bus.cmd_mode = 0;
        bus.cmd_steps = 0; bus.cmd_period_start = 0; bus.cmd_period_min = 0; bus.cmd_accel = 0;

        //           dir   mode       steps ps   pm  acc stopA poke sws delta coil     cyc   tag
        tbl[0] = '{1'b1, MODE_HALF,   8,  10, 10,  0, 0, 0, 1'b0,  8, 4'b1000,   80, 0};
        tbl[1] = '{1'b0, MODE_FULL,   4,   5,  5,  0, 0, 0, 1'b0, -4, 4'b1100,   20, 0};
        tbl[2] = '{1'b1, MODE_WAVE,  20, 100, 40, 20, 0, 0, 1'b0, 20, 4'b0100, 1040, 1};
        tbl[3] = '{1'b1, MODE_FULL,   3, 100, 40, 20, 0, 0, 1'b0,  3, 4'b1100,  280, 2};
        tbl[4] = '{1'b0, MODE_HALF, 503, 100, 40, 20, 3, 0, 1'b0, -6, 4'b0110,  420, 3};
        tbl[5] = '{1'b1, 2'b11,       5,   0,  7,  3, 0, 0, 1'b1,  5, 4'b0011,    5, 0};
        tbl[6] = '{1'b0, MODE_WAVE,   6,  30,  8, 10, 0, 0, 1'b0, -6, 4'b0100,  114, 4};
        tbl[7] = '{1'b1, MODE_HALF,   4,  20, 20,  0, 0, 5, 1'b0,  4, 4'b0001,   80, 0};

        repeat (3) @(negedge clk);
        check("rst_coil", 32'(bus.coil_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pos", bus.position, 32'd0);
        check("rst_left", 32'(bus.steps_left), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_move(tbl[i]);
            case (tbl[i].tag)
                1: begin
                    ref_int = '{100, 80, 60};
                    repeat (14) ref_int.push_back(40);
                    ref_int.push_back(60); ref_int.push_back(80); ref_int.push_back(100);
                    check_intervals("ramp_profile");
                end
                2: begin ref_int = '{100, 80, 100}; check_intervals("triangle_profile"); end
                3: begin ref_int = '{100, 80, 60, 40, 60, 80}; check_intervals("stop_profile"); end
                4: begin ref_int = '{30, 20, 10, 8, 18, 28}; check_intervals("clip_profile"); end
                default: ;
            endcase
        end

        // Reset in the middle of a move.
        @(negedge clk);
        bus.cmd_dir = 1'b1; bus.cmd_mode = MODE_HALF; bus.cmd_steps = 16'd10;
        bus.cmd_period_start = 24'd10; bus.cmd_period_min = 24'd10; bus.cmd_accel = 24'd0;
        bus.cmd_start = 1'b1;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        repeat (35) @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_coil", 32'(bus.coil_out), 32'd0);
        check("mid_rst_pos", bus.position, 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_left", 32'(bus.steps_left), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_done", 32'(bus.done), 32'd0);
        end
        rst = 1'b0;
        m_idx = 0;
        m_pos = 0;

        // Stop while idle does nothing.
        @(negedge clk);
        bus.cmd_stop = 1'b1;
        @(negedge clk);
        bus.cmd_stop = 1'b0;
        check("idle_stop_busy", 32'(bus.busy), 32'd0);
        check("idle_stop_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("idle_stop_busy2", 32'(bus.busy), 32'd0);

        extra = '{1'b1, MODE_HALF, 0, 5, 5, 0, 0, 0, 1'b0, 0, 4'b0000, 0, 0};
        run_move(extra);
        extra = '{1'b1, MODE_HALF, 2, 3, 3, 0, 0, 0, 1'b0, 2, 4'b0100, 6, 0};
        run_move(extra);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
